// File: rtl/instr_sequencer.sv
// Program sequencer: owns the pc, fetches, checks opcodes and drives the execute handshake in run/step/halt modes.
// Optional build macro SEQ_PERF_CNT_EN adds an EXEC_WAIT cycle counter on perf_exec_cycles.
//
// state      | meaning
// IDLE       | waiting for run/step/restart
// FETCH_REQ  | one-cycle fetch request at pc
// FETCH_WAIT | waiting for fetch_valid (watchdog armed)
// DECODE     | end-of-program / opcode check on latched instruction
// EXEC_START | one-cycle execute start pulse
// EXEC_WAIT  | waiting for exec_done (watchdog armed)
// RETIRE     | advance pc, count, continue or stop
// ERROR      | sticky error, only restart leaves
module instr_sequencer #(
   parameter int                    ADDR_WIDTH     = 24,
   parameter int                    INSTR_WIDTH    = 64,
   parameter int                    INSTR_BYTES    = 8,
   parameter logic [ADDR_WIDTH-1:0] START_PC       = '0,
   parameter int                    COUNT_WIDTH    = 16,
   parameter int                    TIMEOUT_CYCLES = 65536
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   step,
   input  logic                   halt_req,
   input  logic                   restart,
   output logic                   fetch_req,
   output logic [ADDR_WIDTH-1:0]  fetch_addr,
   input  logic                   fetch_valid,
   input  logic [INSTR_WIDTH-1:0] fetch_instr,
   output logic                   exec_start,
   output logic [INSTR_WIDTH-1:0] exec_instr,
   output logic [4:0]             exec_opcode,
   input  logic                   exec_done,
   output logic                   busy,
   output logic                   halted,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [COUNT_WIDTH-1:0] instr_count,
   output logic [31:0]            perf_exec_cycles
);

   typedef enum logic [2:0] {
      IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC_START, EXEC_WAIT, RETIRE, ERROR
   } state_t;

   localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);

   state_t          state, state_nxt;
   logic [WD_W-1:0] wd_cnt;
   logic            wd_tc;
   logic            step_mode;
   logic            halt_pend;
   logic            op_legal;
   logic            restart_ok;
   logic            err_set;
   logic [1:0]      err_code_set;

   assign exec_opcode = exec_instr[INSTR_WIDTH-1 -: 5];
   assign op_legal    = (exec_opcode >= 5'd1) && (exec_opcode <= 5'd5);
   assign fetch_addr  = pc;
   assign busy        = (state != IDLE) && (state != ERROR);
   assign restart_ok  = restart && ((state == IDLE) || (state == ERROR));
   assign wd_tc       = WD_EN && (wd_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      fetch_req    = 1'b0;
      exec_start   = 1'b0;
      done         = 1'b0;
      err_set      = 1'b0;
      err_code_set = 2'd0;
      case (state)
         IDLE: begin
            if (!halt_req && (step || run)) state_nxt = FETCH_REQ;
         end
         FETCH_REQ: begin
            fetch_req = 1'b1;
            state_nxt = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (fetch_valid) begin
               state_nxt = DECODE;
            end else if (wd_tc) begin
               err_set      = 1'b1;
               err_code_set = 2'd3;
               state_nxt    = ERROR;
            end
         end
         DECODE: begin
            if (exec_instr == '0) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (!op_legal) begin
               err_set      = 1'b1;
               err_code_set = 2'd1;
               state_nxt    = ERROR;
            end else begin
               state_nxt = EXEC_START;
            end
         end
         EXEC_START: begin
            exec_start = 1'b1;
            state_nxt  = EXEC_WAIT;
         end
         EXEC_WAIT: begin
            if (exec_done) begin
               state_nxt = RETIRE;
            end else if (wd_tc) begin
               err_set      = 1'b1;
               err_code_set = 2'd2;
               state_nxt    = ERROR;
            end
         end
         RETIRE: begin
            state_nxt = (step_mode || halt_pend || halt_req) ? IDLE : FETCH_REQ;
         end
         ERROR: begin
            if (restart) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Watchdog is a down-counter reloaded in the cycle before each wait state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= WD_LOAD;
      end else if ((state == FETCH_REQ) || (state == EXEC_START)) begin
         wd_cnt <= WD_LOAD;
      end else if (((state == FETCH_WAIT) || (state == EXEC_WAIT)) && (wd_cnt != '0)) begin
         wd_cnt <= wd_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= START_PC;
         instr_count <= '0;
         err         <= 1'b0;
         err_code    <= 2'd0;
         exec_instr  <= '0;
         step_mode   <= 1'b0;
         halt_pend   <= 1'b0;
         halted      <= 1'b0;
      end else begin
         if (restart_ok) begin
            pc          <= START_PC;
            instr_count <= '0;
            err         <= 1'b0;
            err_code    <= 2'd0;
         end else if (state == RETIRE) begin
            pc <= pc + ADDR_WIDTH'(INSTR_BYTES);
            if (instr_count != '1) instr_count <= instr_count + COUNT_WIDTH'(1);
         end

         if (err_set && !err) begin
            err      <= 1'b1;
            err_code <= err_code_set;
         end

         if ((state == FETCH_WAIT) && fetch_valid) exec_instr <= fetch_instr;

         if ((state == IDLE) && !halt_req && (step || run)) step_mode <= step;

         if ((state_nxt == IDLE) || (state_nxt == ERROR)) halt_pend <= 1'b0;
         else if (busy && halt_req)                       halt_pend <= 1'b1;

         if (state == IDLE) begin
            if (halt_req)          halted <= 1'b1;
            else if (step || run)  halted <= 1'b0;
         end else if ((state == RETIRE) && (state_nxt == IDLE)) begin
            halted <= 1'b1;
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           perf_cnt <= '0;
      else if (restart_ok)                               perf_cnt <= '0;
      else if ((state == EXEC_WAIT) && (perf_cnt != '1)) perf_cnt <= perf_cnt + 32'd1;
   end

   assign perf_exec_cycles = perf_cnt;
`else
   assign perf_exec_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: fetch/execute responder with a scoreboard of expected instructions and fetch addresses.
// Builds with or without SEQ_PERF_CNT_EN.
module tb_instr_sequencer;

   localparam logic [63:0] I_LOAD = {5'd1, 59'h0000_1234};
   localparam logic [63:0] I_GEMV = {5'd4, 59'h0000_0055};
   localparam logic [63:0] I_BAD  = {5'd7, 59'h0000_0001};
   localparam logic [63:0] I_WRAP = {5'd2, 59'h0000_0009};
`ifdef SEQ_PERF_CNT_EN
   localparam int PERF_T1 = 6;
`else
   localparam int PERF_T1 = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0, step = 1'b0, halt_req = 1'b0, restart = 1'b0;
   logic        fetch_req, exec_start, busy, halted, done, err;
   logic [23:0] fetch_addr, pc;
   logic        fetch_valid = 1'b0;
   logic [63:0] fetch_instr = '0;
   logic [63:0] exec_instr;
   logic [4:0]  exec_opcode;
   logic        exec_done = 1'b0;
   logic [1:0]  err_code;
   logic [15:0] instr_count;
   logic [31:0] perf_exec_cycles;

   logic        w_step = 1'b0;
   logic        w_fetch_req, w_exec_start, w_busy, w_halted, w_done, w_err;
   logic [23:0] w_fetch_addr, w_pc;
   logic        w_fetch_valid = 1'b0, w_exec_done = 1'b0;
   logic        w_fv_nxt = 1'b0, w_ed_nxt = 1'b0;
   logic [63:0] w_exec_instr;
   logic [4:0]  w_exec_opcode;
   logic [1:0]  w_err_code;
   logic [15:0] w_instr_count;
   logic [31:0] w_perf;

   int          n_checks = 0, n_fail = 0;
   int          n_exec = 0, n_fetch = 0, n_done = 0;
   int          cyc = 0, last_fv_cyc = 0;
   int          f_timer = 0, e_timer = 0;
   logic [23:0] f_addr = '0;
   bit          fetch_en = 1'b1, exec_en = 1'b1;
   logic [63:0] mem [0:7];
   logic [63:0] exp_q [$];
   logic [23:0] addr_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_sequencer #(.TIMEOUT_CYCLES(16)) u_dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req), .restart(restart),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
      .fetch_instr(fetch_instr), .exec_start(exec_start), .exec_instr(exec_instr),
      .exec_opcode(exec_opcode), .exec_done(exec_done), .busy(busy), .halted(halted),
      .done(done), .err(err), .err_code(err_code), .pc(pc), .instr_count(instr_count),
      .perf_exec_cycles(perf_exec_cycles)
   );

   instr_sequencer #(.START_PC(24'hFFFFF8)) u_wrap (
      .clk(clk), .rst(rst), .run(1'b0), .step(w_step), .halt_req(1'b0), .restart(1'b0),
      .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr), .fetch_valid(w_fetch_valid),
      .fetch_instr(I_WRAP), .exec_start(w_exec_start), .exec_instr(w_exec_instr),
      .exec_opcode(w_exec_opcode), .exec_done(w_exec_done), .busy(w_busy), .halted(w_halted),
      .done(w_done), .err(w_err), .err_code(w_err_code), .pc(w_pc), .instr_count(w_instr_count),
      .perf_exec_cycles(w_perf)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit is_exec(input logic [63:0] ins);
      return (ins != '0) && (ins[63:59] >= 5'd1) && (ins[63:59] <= 5'd5);
   endfunction

   // Responder and scoreboard: one process so sampling and driving never race.
   initial begin
      logic [63:0] exp_i;
      forever begin
         @(negedge clk);
         if (fetch_en) begin
            fetch_valid = 1'b0;
            if (f_timer > 0) begin
               f_timer--;
               if (f_timer == 0) begin
                  fetch_valid = 1'b1;
                  fetch_instr = mem[f_addr[5:3]];
                  last_fv_cyc = cyc;
                  if (is_exec(fetch_instr)) exp_q.push_back(fetch_instr);
               end
            end
         end
         if (exec_en) begin
            exec_done = 1'b0;
            if (e_timer > 0) begin
               e_timer--;
               if (e_timer == 0) exec_done = 1'b1;
            end
         end
         if (exec_start) begin
            n_exec++;
            check_val("exec_q_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               exp_i = exp_q.pop_front();
               check_val("exec_instr", exec_instr, exp_i);
               check_val("exec_opcode", 64'(exec_opcode), 64'(exp_i[63:59]));
               check_val("fv_to_start_lat", 64'(cyc - last_fv_cyc), 64'd2);
            end
            if (exec_en) e_timer = 3;
         end
         if (fetch_req) begin
            n_fetch++;
            check_val("addr_q_has_entry", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) check_val("fetch_addr", 64'(fetch_addr), 64'(addr_q.pop_front()));
            f_addr = fetch_addr;
            if (fetch_en) f_timer = 1;
         end
         if (done) n_done++;
         w_fetch_valid = w_fv_nxt;
         w_fv_nxt      = w_fetch_req;
         w_exec_done   = w_ed_nxt;
         w_ed_nxt      = w_exec_start;
      end
   end

   task automatic pulse_run();     run = 1'b1;     @(negedge clk); run = 1'b0;     endtask
   task automatic pulse_step();    step = 1'b1;    @(negedge clk); step = 1'b0;    endtask
   task automatic pulse_restart(); restart = 1'b1; @(negedge clk); restart = 1'b0; endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max && busy; i++) @(negedge clk);
      check_val("idle_reached", 64'(busy), 64'd0);
   endtask

   task automatic wait_exec_start(input int max);
      for (int i = 0; i < max && !exec_start; i++) @(negedge clk);
      check_val("exec_start_seen", 64'(exec_start), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int snap_exec, snap_fetch, snap_done;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      mem[0] = I_LOAD;
      mem[1] = I_GEMV;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_val("rst_pc", 64'(pc), 64'd0);
      check_val("rst_count", 64'(instr_count), 64'd0);
      check_val("rst_err", 64'({err, err_code}), 64'd0);
      check_val("rst_busy_halted", 64'({busy, halted}), 64'd0);
      check_val("rst_exec_instr", exec_instr, 64'd0);
      check_val("rst_perf", 64'(perf_exec_cycles), 64'd0);

      // Continuous run of {LOAD, GEMV, end}
      snap_exec = n_exec; snap_done = n_done;
      addr_q.push_back(24'd0); addr_q.push_back(24'd8); addr_q.push_back(24'd16);
      pulse_run();
      check_val("run_to_fetch_lat", 64'(fetch_req), 64'd1);
      wait_idle(200);
      repeat (2) @(negedge clk);
      check_val("run_exec_count", 64'(n_exec - snap_exec), 64'd2);
      check_val("run_pc", 64'(pc), 64'd16);
      check_val("run_count", 64'(instr_count), 64'd2);
      check_val("run_done_pulses", 64'(n_done - snap_done), 64'd1);
      check_val("run_halted", 64'(halted), 64'd0);
      check_val("run_addr_q_drained", 64'(addr_q.size()), 64'd0);
      check_val("run_perf", 64'(perf_exec_cycles), 64'(PERF_T1));

      // Single step twice
      pulse_restart();
      check_val("restart_pc", 64'(pc), 64'd0);
      check_val("restart_count", 64'(instr_count), 64'd0);
      check_val("restart_perf", 64'(perf_exec_cycles), 64'd0);
      snap_exec = n_exec;
      addr_q.push_back(24'd0);
      pulse_step();
      wait_idle(100);
      check_val("step1_exec", 64'(n_exec - snap_exec), 64'd1);
      check_val("step1_pc", 64'(pc), 64'd8);
      check_val("step1_halted", 64'(halted), 64'd1);
      addr_q.push_back(24'd8);
      pulse_step();
      wait_idle(100);
      check_val("step2_pc", 64'(pc), 64'd16);
      check_val("step2_count", 64'(instr_count), 64'd2);

      // Halt during EXEC_WAIT of the first instruction, then resume
      pulse_restart();
      addr_q.push_back(24'd0);
      pulse_run();
      wait_exec_start(50);
      @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      wait_idle(100);
      check_val("halt_pc", 64'(pc), 64'd8);
      check_val("halt_halted", 64'(halted), 64'd1);
      check_val("halt_count", 64'(instr_count), 64'd1);
      snap_fetch = n_fetch;
      repeat (8) @(negedge clk);
      check_val("halt_no_fetch", 64'(n_fetch - snap_fetch), 64'd0);
      addr_q.push_back(24'd8); addr_q.push_back(24'd16);
      pulse_run();
      wait_idle(200);
      check_val("resume_pc", 64'(pc), 64'd16);
      check_val("resume_halted", 64'(halted), 64'd0);
      check_val("resume_addr_q_drained", 64'(addr_q.size()), 64'd0);

      // Illegal opcode
      pulse_restart();
      mem[0] = I_BAD;
      snap_exec = n_exec;
      addr_q.push_back(24'd0);
      pulse_run();
      wait_idle(50);
      check_val("illegal_err", 64'({err, err_code}), 64'({1'b1, 2'd1}));
      check_val("illegal_no_exec", 64'(n_exec - snap_exec), 64'd0);
      snap_fetch = n_fetch;
      pulse_run();
      repeat (5) @(negedge clk);
      check_val("error_run_ignored", 64'(n_fetch - snap_fetch), 64'd0);
      check_val("error_code_held", 64'({busy, err, err_code}), 64'({1'b0, 1'b1, 2'd1}));
      mem[0] = I_LOAD;
      pulse_restart();
      check_val("err_restart_pc", 64'(pc), 64'd0);
      check_val("err_restart_err", 64'({err, err_code}), 64'd0);

      // Execute watchdog
      exec_en = 1'b0;
      addr_q.push_back(24'd0);
      pulse_run();
      wait_exec_start(50);
      repeat (16) @(negedge clk);
      check_val("exec_to_early", 64'(err), 64'd0);
      @(negedge clk);
      check_val("exec_to_err", 64'({err, err_code}), 64'({1'b1, 2'd2}));
      pulse_restart();
      exec_en = 1'b1;

      // Fetch watchdog
      fetch_en = 1'b0;
      addr_q.push_back(24'd0);
      pulse_run();
      check_val("fetch_to_req", 64'(fetch_req), 64'd1);
      repeat (16) @(negedge clk);
      check_val("fetch_to_early", 64'(err), 64'd0);
      @(negedge clk);
      check_val("fetch_to_err", 64'({err, err_code}), 64'({1'b1, 2'd3}));
      pulse_restart();
      fetch_en = 1'b1;

      // Reset in EXEC_WAIT with exec_done in the same cycle
      exec_en = 1'b0;
      addr_q.push_back(24'd0);
      pulse_run();
      wait_exec_start(50);
      @(negedge clk);
      exec_done = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exec_done = 1'b0;
      exec_en = 1'b1;
      repeat (4) @(negedge clk);
      check_val("arst_pc", 64'(pc), 64'd0);
      check_val("arst_count", 64'(instr_count), 64'd0);
      check_val("arst_busy", 64'({busy, err, halted}), 64'd0);
      check_val("arst_exec_instr", exec_instr, 64'd0);

      // pc wrap on the START_PC = 2^24-8 instance
      check_val("wrap_rst_pc", 64'(w_pc), 64'hFFFFF8);
      w_step = 1'b1;
      @(negedge clk);
      w_step = 1'b0;
      for (int i = 0; i < 50 && w_busy; i++) @(negedge clk);
      check_val("wrap_idle", 64'(w_busy), 64'd0);
      check_val("wrap_pc", 64'(w_pc), 64'd0);
      check_val("wrap_count_halted", 64'({w_instr_count, w_halted}), 64'({16'd1, 1'b1}));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
